// File: rtl/trg_frame_serializer.sv
// Turns one BX of trigger clusters into four 16-bit words (plus charisk) per link; optional TRG_OVERFLOW_CHAR_EN marks overflow with K28.3.
// Latency: word k of a frame strobed in cycle N is registered out in cycle N+1+k.
// Backpressure: none; ready_i low swaps data for filler while framing keeps running.
`timescale 1ns/1ps
module trg_frame_serializer #(
  parameter int ALLOW_TTC_CHARS = 1,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                     clock_160,
  input  logic                     reset_i,
  input  logic                     frame_strobe_i,
  input  logic [111:0]             gem_data_i,
  input  logic                     overflow_i,
  input  logic                     bc0_i,
  input  logic                     resync_i,
  input  logic                     ready_i,
  output logic [15:0]              trg_tx_data_a,
  output logic [15:0]              trg_tx_data_b,
  output logic [1:0]               trg_tx_isk_a,
  output logic [1:0]               trg_tx_isk_b,
  output logic                     frame_locked_o,
  output logic [ERR_CNT_WIDTH-1:0] phase_err_cnt_o
);
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [1:0]               phase_q, phase_d;
  logic                     data_on_q, data_on_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [111:0]             frame_q, frame_d;
  logic                     bc0_q, bc0_d;
  logic                     resync_q, resync_d;
  logic                     ovf_d;
  logic [7:0]               char_d;
  logic [15:0]              word_a_d, word_b_d;
  logic [1:0]               isk_d;

`ifdef TRG_OVERFLOW_CHAR_EN
  logic                     ovf_q;
`else
  logic                     unused_overflow;
  assign unused_overflow = overflow_i;
`endif

  function automatic logic [15:0] frame_word(input logic [55:0] d, input logic [1:0] ph,
                                             input logic [7:0] ch);
    case (ph)
      2'd0:    frame_word = {d[7:0], ch};
      2'd1:    frame_word = d[23:8];
      2'd2:    frame_word = d[39:24];
      default: frame_word = d[55:40];
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q + 2'd1;
    err_d    = err_q;
    frame_d  = frame_q;
    bc0_d    = bc0_q;
    resync_d = resync_q;
`ifdef TRG_OVERFLOW_CHAR_EN
    ovf_d    = ovf_q;
`else
    ovf_d    = 1'b0;
`endif
    if (frame_strobe_i) begin
      phase_d  = 2'd0;
      state_d  = RUN;
      frame_d  = gem_data_i;
      bc0_d    = bc0_i;
      resync_d = resync_i;
`ifdef TRG_OVERFLOW_CHAR_EN
      ovf_d    = overflow_i;
`endif
      // A strobe while running off the 4-cycle cadence abandons the frame in flight.
      if (state_q == RUN && phase_q != 2'd3 && err_q != ERR_MAX)
        err_d = err_q + ERR_ONE;
    end else if (state_q == RUN && phase_q == 2'd3) begin
      state_d = IDLE;
    end
    // Data is only re-enabled on a word0 boundary so no partial frame escapes.
    data_on_d = ready_i && ((phase_d == 2'd0) || data_on_q);
  end

  always_comb begin
    if (ALLOW_TTC_CHARS != 0 && resync_d)
      char_d = K28_2;
    else if (ALLOW_TTC_CHARS != 0 && bc0_d)
      char_d = K28_1;
    else if (ovf_d)
      char_d = K28_3;
    else
      char_d = K28_5;
  end

  always_comb begin
    word_a_d = 16'h0000;
    word_b_d = 16'h0000;
    isk_d    = 2'b00;
    if (state_d == RUN && data_on_d) begin
      word_a_d = frame_word(frame_d[55:0], phase_d, char_d);
      word_b_d = frame_word(frame_d[111:56], phase_d, char_d);
      isk_d    = (phase_d == 2'd0) ? 2'b01 : 2'b00;
    end else if (phase_d == 2'd0) begin
      word_a_d = {8'h00, K28_5};
      word_b_d = {8'h00, K28_5};
      isk_d    = 2'b01;
    end
  end

  always_ff @(posedge clock_160 or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      phase_q       <= 2'd3;
      data_on_q     <= 1'b0;
      err_q         <= '0;
      frame_q       <= '0;
      bc0_q         <= 1'b0;
      resync_q      <= 1'b0;
`ifdef TRG_OVERFLOW_CHAR_EN
      ovf_q         <= 1'b0;
`endif
      trg_tx_data_a <= 16'h0000;
      trg_tx_data_b <= 16'h0000;
      trg_tx_isk_a  <= 2'b00;
      trg_tx_isk_b  <= 2'b00;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      data_on_q     <= data_on_d;
      err_q         <= err_d;
      frame_q       <= frame_d;
      bc0_q         <= bc0_d;
      resync_q      <= resync_d;
`ifdef TRG_OVERFLOW_CHAR_EN
      ovf_q         <= ovf_d;
`endif
      trg_tx_data_a <= word_a_d;
      trg_tx_data_b <= word_b_d;
      trg_tx_isk_a  <= isk_d;
      trg_tx_isk_b  <= isk_d;
    end
  end

  assign frame_locked_o  = (state_q == RUN);
  assign phase_err_cnt_o = err_q;

endmodule
